cipher_stream_buffer: RTL and testbench
=======================================

CIPHER_STREAM_BUFFER -- requirements
Module: cipher_stream_buffer

Interface
REQ-001 Parameter WIDTH, default 8: byte width of the cipher data path; matches the encryption unit dout.
REQ-002 Parameter DEPTH, default 8: number of FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_v  input  1  write strobe, driven by the encryption unit's v output.
REQ-006 in_data  input  WIDTH  cipher byte, driven by the encryption unit's dout.
REQ-007 flush  input  1  synchronous clear of the FIFO contents and the overflow flag.
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_ready  input  1  consumer accepts the head entry.
REQ-010 out_data  output  WIDTH  head entry, first-word-fall-through.
REQ-011 level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 full  output  1  level equals DEPTH.
REQ-013 overflow  output  1  sticky drop indicator.

Function
REQ-014 The block SHALL capture in_data on every clk edge where in_v=1 and a write is permitted.
REQ-015 A write SHALL be permitted when full=0, or when full=1 and a pop occurs in the same cycle.
REQ-016 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-017 out_valid SHALL equal (level != 0); out_data SHALL present the oldest entry with zero added latency.
REQ-018 A byte written into an empty FIFO SHALL appear on out_data with out_valid=1 in the next cycle.
REQ-019 level SHALL increment on a write without a pop, decrement on a pop without a write, and hold on both or neither.
REQ-020 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-021 When in_v=1 and the write is not permitted, the byte SHALL be dropped, FIFO state SHALL be unchanged, and overflow SHALL set to 1 on the next edge.
REQ-022 overflow SHALL remain 1 until reset or flush.
REQ-023 When flush=1, level SHALL become 0, both pointers 0, and overflow 0 on the next edge; in_v and pops in that cycle SHALL be ignored.
REQ-024 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-025 When the FIFO is empty, out_data SHALL be don't-care, and it SHALL NOT be X-propagated into level or full.

Reset
REQ-026 While rst=1: level=0, full=0, out_valid=0, overflow=0, and both pointers 0, regardless of clk.
REQ-027 Storage array contents need not be reset.
REQ-028 Assertion of rst mid-transfer SHALL discard all entries; the first write after deassertion SHALL be the next head.

Configuration
REQ-029 Macro ENCRYPT_BUF_PARITY_EN SHALL control parity support.
REQ-030 With ENCRYPT_BUF_PARITY_EN defined:
- Each entry SHALL store WIDTH+1 bits; the extra bit is the even parity (XOR reduction) of in_data, computed at write.
- Output port out_parity (1 bit) SHALL present the stored parity of the head entry.
- out_parity SHALL reset to 0.
REQ-031 Without ENCRYPT_BUF_PARITY_EN, out_parity and the extra storage bit SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-032 Reset then idle: rst=1 for 3 cycles -> level=0, out_valid=0, full=0, overflow=0 during and after reset.
REQ-033 Single byte: in_v=1 with in_data=8'hFA for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_data=8'hFA, level=1, held for 5 cycles; then out_ready=1 -> level=0 after 1 edge.
REQ-034 Fill and overflow:
- Write 8'h00..8'h07 (DEPTH=8) -> full=1, level=8.
- Write 8'h08 with out_ready=0 -> dropped, overflow=1.
- Drain -> out_data sequence is 8'h00..8'h07 and overflow stays 1.
REQ-035 Simultaneous events and wrap: at full, in_v=1 with 8'hA5 and out_ready=1 in the same cycle -> level stays 8, overflow stays 0; drain -> 8'hA5 is last; repeat 3 fills to exercise pointer wrap.
REQ-036 Flush and mid-operation reset:
- At level=5, flush=1 with in_v=1 -> level=0, overflow=0 next cycle.
- Refill 3 bytes, assert rst asynchronously between edges -> out_valid=0 immediately.
REQ-037 Parity (macro defined): write 8'h03 then 8'h07 -> out_parity 0 then 1, aligned with out_data.

Source files
------------

// File: rtl/cipher_stream_buffer.sv
// First-word-fall-through FIFO that buffers cipher bytes from the encryption unit.
// Define ENCRYPT_BUF_PARITY_EN to store an even-parity bit per entry and expose out_parity.
`timescale 1ns/1ps

module cipher_stream_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_v,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
`ifdef ENCRYPT_BUF_PARITY_EN
    output logic                     out_parity,
`endif
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef ENCRYPT_BUF_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    function automatic logic calc_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          pop_s, push_s, drop_s;
    logic [EW-1:0] entry_s;
    logic [EW-1:0] head_s;

    // Handshake decode; a pop frees the slot the same-cycle write lands in when full.
    always_comb begin
        pop_s  = valid_q && out_ready && !flush;
        push_s = in_v && (!full_q || pop_s) && !flush;
        drop_s = in_v && full_q && !pop_s && !flush;
    end

    // Next-state for pointers, occupancy and the sticky drop flag.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (flush) begin
            rd_ptr_d   = {AW{1'b0}};
            wr_ptr_d   = {AW{1'b0}};
            level_d    = {LW{1'b0}};
            overflow_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (drop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
        valid_d = (level_d != {LW{1'b0}});
        full_d  = (level_d == LW'(DEPTH));
    end

    // Entry formatting at write time.
    always_comb begin
`ifdef ENCRYPT_BUF_PARITY_EN
        entry_s = {calc_parity(in_data), in_data};
`else
        entry_s = in_data;
`endif
    end

    // Control state; status outputs come straight from these flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            level_q    <= {LW{1'b0}};
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are not reset, occupancy alone qualifies them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_q] <= entry_s;
        end
    end

    // Head entry, forced to zero when empty so uninitialised storage never escapes.
    always_comb begin
        if (valid_q) begin
            head_s = mem[rd_ptr_q];
        end else begin
            head_s = {EW{1'b0}};
        end
    end

    assign out_valid = valid_q;
    assign out_data  = head_s[WIDTH-1:0];
    assign level     = level_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
`ifdef ENCRYPT_BUF_PARITY_EN
    assign out_parity = head_s[WIDTH];
`endif

endmodule

// File: tb/tb_cipher_stream_buffer.sv
// Scoreboard bench for cipher_stream_buffer: directed stimulus pushes expected bytes,
// a negedge monitor pops and compares them whenever a pop is presented.
`timescale 1ns/1ps

module tb_cipher_stream_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             in_v;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       level;
    logic             full;
    logic             overflow;
`ifdef ENCRYPT_BUF_PARITY_EN
    logic             out_parity;
`endif

    int checks   = 0;
    int failures = 0;

    // Each entry is {parity, data}.
    logic [WIDTH:0] exp_q[$];

    cipher_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_v      (in_v),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
`ifdef ENCRYPT_BUF_PARITY_EN
        .out_parity(out_parity),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] d);
        exp_q.push_back({^d, d});
    endtask

    task automatic write_byte(input logic [WIDTH-1:0] d, input bit expect_kept);
        in_v    = 1'b1;
        in_data = d;
        if (expect_kept) push_exp(d);
        step();
        in_v = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH + 4 && level != 4'd0; k++) step();
        out_ready = 1'b0;
        chk("drain_done", {28'd0, level}, 32'd0);
    endtask

    // Monitor: a pop happens at the next posedge whenever valid & ready without flush.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got data %0h expected no entry at %0t", out_data, $time);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                if (out_data !== e[WIDTH-1:0]) begin
                    failures++;
                    $display("FAIL pop_data: got %0h expected %0h at %0t", out_data, e[WIDTH-1:0], $time);
                end
`ifdef ENCRYPT_BUF_PARITY_EN
                checks++;
                if (out_parity !== e[WIDTH]) begin
                    failures++;
                    $display("FAIL pop_parity: got %0b expected %0b at %0t", out_parity, e[WIDTH], $time);
                end
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; in_v = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b0;

        // Reset held for 3 cycles, idle outputs during and after.
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_level", {28'd0, level}, 32'd0);
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_level", {28'd0, level}, 32'd0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        // Single byte, held while out_ready=0.
        write_byte(8'hFA, 1'b1);
        for (int c = 0; c < 5; c++) begin
            chk("single_valid", {31'd0, out_valid}, 32'd1);
            chk("single_data", {24'd0, out_data}, 32'h0000_00FA);
            chk("single_level", {28'd0, level}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_pop_level", {28'd0, level}, 32'd0);
        chk("single_pop_valid", {31'd0, out_valid}, 32'd0);

        // Fill, overflow drop, drain in order with sticky overflow.
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i), 1'b1);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_level", {28'd0, level}, 32'd8);
        chk("fill_ovf", {31'd0, overflow}, 32'd0);
        write_byte(8'h08, 1'b0);
        chk("drop_ovf", {31'd0, overflow}, 32'd1);
        chk("drop_level", {28'd0, level}, 32'd8);
        drain();
        chk("drain_ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("drain_sb_empty", exp_q.size(), 32'd0);

        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ovf", {31'd0, overflow}, 32'd0);
        chk("flush_level", {28'd0, level}, 32'd0);

        // Simultaneous write+pop at full, three rounds to wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h10 * (r + 1) + i), 1'b1);
            out_ready = 1'b1;
            write_byte(8'hA5, 1'b1);
            out_ready = 1'b0;
            chk("simul_level", {28'd0, level}, 32'd8);
            chk("simul_full", {31'd0, full}, 32'd1);
            chk("simul_ovf", {31'd0, overflow}, 32'd0);
            drain();
            chk("simul_sb_empty", exp_q.size(), 32'd0);
        end

        // Flush at level 5 with a write and pop in the same cycle.
        for (int i = 0; i < 5; i++) write_byte(8'(8'hC0 + i), 1'b1);
        chk("pre_flush_level", {28'd0, level}, 32'd5);
        flush = 1'b1; in_v = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        step();
        flush = 1'b0; in_v = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        chk("flush5_level", {28'd0, level}, 32'd0);
        chk("flush5_valid", {31'd0, out_valid}, 32'd0);
        chk("flush5_ovf", {31'd0, overflow}, 32'd0);

        // Asynchronous reset between edges with 3 bytes buffered.
        for (int i = 0; i < 3; i++) write_byte(8'(8'h30 + i), 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_level", {28'd0, level}, 32'd0);
        exp_q.delete();
        step();
        rst = 1'b0;
        write_byte(8'h7B, 1'b1);
        chk("after_rst_head", {24'd0, out_data}, 32'h0000_007B);
        chk("after_rst_level", {28'd0, level}, 32'd1);
        drain();

`ifdef ENCRYPT_BUF_PARITY_EN
        // Parity aligned with data: 8'h03 -> 0, 8'h07 -> 1.
        write_byte(8'h03, 1'b1);
        write_byte(8'h07, 1'b1);
        chk("par_head0", {31'd0, out_parity}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("par_head1_data", {24'd0, out_data}, 32'h0000_0007);
        chk("par_head1", {31'd0, out_parity}, 32'd1);
        drain();
`endif

        chk("final_sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
